down_counter_underflow: RTL and testbench

- Loadable down-counter with sticky underflow flag; the count-down counterpart of the team's 4-bit up-counter with overflow.
- Used as a countdown timer or credit counter: software or a controller loads a start value, enable pulses decrement it, and borrow is reported.
- Adds a one-cycle terminal-count pulse, an optional auto-reload mode, and a 3-state control FSM.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/sticky_flag.sv | 20 ++
 rtl/down_counter_underflow.sv | 88 ++++++++
 tb/tb_down_counter_underflow.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and arithmetic for the up/down counter family.
package counter_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_RUN,
    CNT_EXPIRED
  } cnt_state_e;

  // Returns {borrow, next_count}: for any counter width W <= CNT_MAX_W, bit W of
  // the zero-extended difference is the borrow and bits [W-1:0] the wrapped count.
  function automatic logic [CNT_MAX_W:0] cnt_dec(
    input logic [CNT_MAX_W-1:0] count,
    input logic [CNT_MAX_W-1:0] step
  );
    return {1'b0, count} - {1'b0, step};
  endfunction

endpackage

// File: rtl/sticky_flag.sv
// Set-dominant sticky flag with synchronous active-high reset.
module sticky_flag (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set,
  input  logic i_clr,
  output logic o_flag
);

  logic r_flag;

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_flag <= 1'b0;
    else if (i_set) r_flag <= 1'b1;
    else if (i_clr) r_flag <= 1'b0;
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/down_counter_underflow.sv
// Loadable down-counter with sticky underflow, terminal-count pulse and
// optional auto-reload, controlled by an IDLE/RUN/EXPIRED state machine.
module down_counter_underflow
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned STEP        = 1,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             clear_underflow,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             tc_pulse,
  output logic             busy_out
);

  cnt_state_e       r_state;
  cnt_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH:0]   w_dec;
  logic             r_tc;
  logic             r_busy;
  logic             w_borrow;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_borrow    = 1'b0;
    w_dec       = (WIDTH+1)'(cnt_dec(CNT_MAX_W'(r_count), CNT_MAX_W'(STEP)));
    if (load) begin
      w_count_nxt = load_value;
      w_state_nxt = CNT_IDLE;
    end else begin
      case (r_state)
        CNT_IDLE, CNT_RUN: begin
          if (enable) begin
            w_borrow    = w_dec[WIDTH];
            w_count_nxt = w_dec[WIDTH-1:0];
            w_state_nxt = CNT_RUN;
            if (w_dec[WIDTH]) begin
              if (AUTO_RELOAD) w_count_nxt = r_reload;
              else             w_state_nxt = CNT_EXPIRED;
            end
          end
        end
        CNT_EXPIRED: w_state_nxt = CNT_EXPIRED;
        default:     w_state_nxt = CNT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= CNT_IDLE;
      r_count  <= '1;
      r_reload <= '1;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (load) r_reload <= load_value;
      r_tc    <= w_borrow;
      r_busy  <= (w_state_nxt == CNT_RUN);
    end
  end

  // A load never borrows, so it can share the clear path with clear_underflow.
  sticky_flag u_underflow (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_set  (w_borrow),
    .i_clr  (clear_underflow | load),
    .o_flag (underflow_out)
  );

  assign counter_out = r_count;
  assign tc_pulse    = r_tc;
  assign busy_out    = r_busy;

endmodule

// File: tb/tb_down_counter_underflow.sv
// Three counter configurations driven by one directed stimulus stream and
// checked every cycle against a behavioural model.
module tb_down_counter_underflow;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       enable = 1'b0;
  logic       clear_underflow = 1'b0;

  logic [3:0] cnt_o  [3];
  logic       uf_o   [3];
  logic       tc_o   [3];
  logic       busy_o [3];

  int total = 0;
  int bad   = 0;

  // Instance 0: STEP=1 wrap; 1: STEP=1 auto-reload; 2: STEP=2 wrap.
  int P_STEP [3] = '{1, 1, 2};
  bit P_AR   [3] = '{1'b0, 1'b1, 1'b0};

  int m_cnt [3];
  int m_rl  [3];
  bit m_uf  [3];
  bit m_tc  [3];
  bit m_run [3];
  bit m_exp [3];
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  down_counter_underflow #(.WIDTH(4), .STEP(1), .AUTO_RELOAD(1'b0)) u_a (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .clear_underflow(clear_underflow),
    .counter_out(cnt_o[0]), .underflow_out(uf_o[0]), .tc_pulse(tc_o[0]), .busy_out(busy_o[0]));

  down_counter_underflow #(.WIDTH(4), .STEP(1), .AUTO_RELOAD(1'b1)) u_b (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .clear_underflow(clear_underflow),
    .counter_out(cnt_o[1]), .underflow_out(uf_o[1]), .tc_pulse(tc_o[1]), .busy_out(busy_o[1]));

  down_counter_underflow #(.WIDTH(4), .STEP(2), .AUTO_RELOAD(1'b0)) u_c (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .clear_underflow(clear_underflow),
    .counter_out(cnt_o[2]), .underflow_out(uf_o[2]), .tc_pulse(tc_o[2]), .busy_out(busy_o[2]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
    end
  endtask

  // Model of one clock edge, applied from the same inputs the DUTs sample.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] = 15; m_rl[i] = 15;
        m_uf[i] = 0; m_tc[i] = 0; m_run[i] = 0; m_exp[i] = 0;
      end else if (load) begin
        m_cnt[i] = int'(load_value); m_rl[i] = int'(load_value);
        m_uf[i] = 0; m_tc[i] = 0; m_run[i] = 0; m_exp[i] = 0;
      end else if (enable && !m_exp[i]) begin
        m_run[i] = 1;
        if (m_cnt[i] < P_STEP[i]) begin
          m_tc[i] = 1; m_uf[i] = 1;
          if (P_AR[i]) m_cnt[i] = m_rl[i];
          else begin
            m_cnt[i] = (m_cnt[i] + 16 - P_STEP[i]) % 16;
            m_run[i] = 0; m_exp[i] = 1;
          end
        end else begin
          m_cnt[i] = m_cnt[i] - P_STEP[i];
          m_tc[i] = 0;
          if (clear_underflow) m_uf[i] = 0;
        end
      end else begin
        m_tc[i] = 0;
        if (clear_underflow) m_uf[i] = 0;
      end
    end
    if (reset) mvalid = 1'b1;
  endtask

  task automatic cyc(input bit r, input bit ld, input logic [3:0] lv, input bit en, input bit cl);
    reset = r; load = ld; load_value = lv; enable = en; clear_underflow = cl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Hand-computed expectations pinning both the DUT and the model.
  task automatic lit(input string tag, input int idx, input logic [3:0] c,
                     input bit u, input bit t, input bit b);
    chk($sformatf("%s.cnt%0d", tag, idx),   32'(cnt_o[idx]),  32'(c));
    chk($sformatf("%s.uf%0d", tag, idx),    32'(uf_o[idx]),   32'(u));
    chk($sformatf("%s.tc%0d", tag, idx),    32'(tc_o[idx]),   32'(t));
    chk($sformatf("%s.busy%0d", tag, idx),  32'(busy_o[idx]), 32'(b));
    chk($sformatf("%s.model%0d", tag, idx), 32'(m_cnt[idx]),  32'(c));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("cyc.cnt%0d", i),  32'(cnt_o[i]),  32'(m_cnt[i]));
          chk($sformatf("cyc.uf%0d", i),   32'(uf_o[i]),   32'(m_uf[i]));
          chk($sformatf("cyc.tc%0d", i),   32'(tc_o[i]),   32'(m_tc[i]));
          chk($sformatf("cyc.busy%0d", i), 32'(busy_o[i]), 32'(m_run[i]));
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 4'd0, 0, 0);
    lit("rst", 0, 4'hF, 0, 0, 0);
    lit("rst", 2, 4'hF, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 4'd0, 0, 0);
    lit("hold", 0, 4'hF, 0, 0, 0);

    cyc(0, 1, 4'd3, 0, 0);
    lit("ld3", 0, 4'd3, 0, 0, 0);
    cyc(0, 0, 4'd0, 1, 0); lit("dn2", 0, 4'd2, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("dn1", 0, 4'd1, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("dn0", 0, 4'd0, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("wrap", 0, 4'hF, 1, 1, 0);
    lit("rld3", 1, 4'd3, 1, 1, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("expd", 0, 4'hF, 1, 0, 0);

    cyc(0, 1, 4'd2, 0, 0);
    cyc(0, 0, 4'd0, 1, 0); lit("ar1", 1, 4'd1, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("ar0", 1, 4'd0, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("ar2", 1, 4'd2, 1, 1, 1);
    cyc(0, 0, 4'd0, 1, 1); lit("arclr", 1, 4'd1, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("ar0b", 1, 4'd0, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 1); lit("setwin", 1, 4'd2, 1, 1, 1);
    lit("expclr", 0, 4'hF, 0, 0, 0);

    cyc(0, 1, 4'd5, 0, 0);
    cyc(0, 0, 4'd0, 1, 0); lit("s2a", 2, 4'd3, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("s2b", 2, 4'd1, 0, 0, 1);
    cyc(0, 0, 4'd0, 1, 0); lit("s2wrap", 2, 4'hF, 1, 1, 0);

    cyc(0, 1, 4'd7, 1, 0);
    lit("ldwin", 0, 4'd7, 0, 0, 0);
    lit("ldwin", 2, 4'd7, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 4'd0, 1, 0);
    lit("run4", 0, 4'd4, 0, 0, 1);
    cyc(1, 1, 4'd9, 1, 0);
    lit("midrst", 0, 4'hF, 0, 0, 0);
    lit("midrst", 1, 4'hF, 0, 0, 0);

    for (int k = 0; k < 16; k++) cyc(0, 0, 4'd0, 1, 0);
    lit("rstrld", 1, 4'hF, 1, 1, 1);

    cyc(0, 1, 4'd0, 0, 0);
    cyc(0, 0, 4'd0, 1, 0);
    lit("idleb", 0, 4'hF, 1, 1, 0);
    lit("idleb", 1, 4'd0, 1, 1, 1);
    cyc(0, 0, 4'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
